// File: rtl/timer_run_controller.sv
// Run/pause/clear sequencer for the mm.ss counter chain: gates the 1 kHz tick
// into the chain enable, latches count direction and blinks an alarm at terminal count.
module timer_run_controller #(
    parameter int BLINK_TICKS = 500,
    parameter int ALARM_TICKS = 5000,
    parameter int TCNT_WIDTH  = 13
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       TICK,
    input  logic       START_STOP,
    input  logic       CLEAR,
    input  logic       DIR_SEL,
    input  logic       AT_ZERO,
    input  logic       AT_MAX,
    output logic       COUNT_EN,
    output logic       COUNT_DIR,
    output logic       CHAIN_CLR,
    output logic [1:0] STATE,
    output logic       RUNNING,
    output logic       ALARM
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [TCNT_WIDTH-1:0] BLINK_LAST = TCNT_WIDTH'(BLINK_TICKS - 1);
    localparam logic [TCNT_WIDTH-1:0] ALARM_LAST = TCNT_WIDTH'(ALARM_TICKS - 1);

    state_t                state;
    logic [TCNT_WIDTH-1:0] blink_cnt;
    logic [TCNT_WIDTH-1:0] dur_cnt;
    logic                  term;
    logic                  start_blocked;

    // Terminal test uses the latched direction; the start guard uses the requested one.
    assign term          = COUNT_DIR ? AT_ZERO : AT_MAX;
    assign start_blocked = DIR_SEL ? AT_ZERO : AT_MAX;

    // The tick passes straight through so the chain advances on the same edge.
    assign COUNT_EN = TICK & (state == ST_RUN) & ~term;
    assign STATE    = state;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state     <= ST_IDLE;
            COUNT_DIR <= 1'b0;
            CHAIN_CLR <= 1'b0;
            RUNNING   <= 1'b0;
            ALARM     <= 1'b0;
            blink_cnt <= '0;
            dur_cnt   <= '0;
        end else begin
            // NOTE: non-blocking throughout, so every branch below decides on pre-edge values.
            CHAIN_CLR <= CLEAR;
            case (state)
                ST_IDLE, ST_PAUSE: begin
                    if (CLEAR) begin
                        state   <= ST_IDLE;
                        RUNNING <= 1'b0;
                    end else if (START_STOP && !start_blocked) begin
                        state     <= ST_RUN;
                        RUNNING   <= 1'b1;
                        COUNT_DIR <= DIR_SEL;
                    end
                end
                ST_RUN: begin
                    if (CLEAR) begin
                        state   <= ST_IDLE;
                        RUNNING <= 1'b0;
                    end else if (term) begin
                        state     <= ST_DONE;
                        RUNNING   <= 1'b0;
                        ALARM     <= 1'b1;
                        blink_cnt <= '0;
                        dur_cnt   <= '0;
                    end else if (START_STOP) begin
                        state   <= ST_PAUSE;
                        RUNNING <= 1'b0;
                    end
                end
                ST_DONE: begin
                    // Acknowledge keeps the chain value; only CLEAR wipes it.
                    if (CLEAR || START_STOP) begin
                        state <= ST_IDLE;
                        ALARM <= 1'b0;
                    end else if (TICK) begin
                        if (dur_cnt == ALARM_LAST) begin
                            state <= ST_IDLE;
                            ALARM <= 1'b0;
                        end else begin
                            dur_cnt <= dur_cnt + 1'b1;
                            if (blink_cnt == BLINK_LAST) begin
                                blink_cnt <= '0;
                                ALARM     <= ~ALARM;
                            end else begin
                                blink_cnt <= blink_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    RUNNING <= 1'b0;
                    ALARM   <= 1'b0;
                end
            endcase
        end
    end

endmodule
